cordic: RTL and testbench

// - Iterative rotation-mode CORDIC: rotates the vector (x_start, y_start) by the signed angle `angle`.
// - With x_start = 1/K (0x26DD) and y_start = 0, the outputs are cosine/sine of `angle`.
// - Multi-cycle engine, one micro-rotation per clock, with a start/done handshake; serves sin/cos generation datapaths.

---
 rtl/cordic.sv | 169 ++++++++++++++++
 tb/tb_cordic.sv | 117 +++++++++++
 2 files changed

// File: rtl/cordic.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, start/done handshake.
// Define CORDIC_SAT_EN to saturate (instead of wrap) when narrowing x/y to WIDTH bits.
module cordic #(
  parameter int WIDTH       = 16,
  parameter int ITERATIONS  = 15,
  parameter int ANGLE_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       x_start,
  input  logic [WIDTH-1:0]       y_start,
  input  logic [ANGLE_WIDTH-1:0] angle,
  output logic [WIDTH-1:0]       cosine,
  output logic [WIDTH-1:0]       sine,
  output logic                   done
);

  localparam int XW = WIDTH + 2;
  localparam int ZW = ANGLE_WIDTH + 1;
  localparam int SH = 32 - ANGLE_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    ROTATE,
    DONE
  } state_e;

  function automatic logic signed [ZW-1:0] scale(input logic [31:0] c);
    logic signed [31:0] s;
    s = $signed(c) >>> SH;
    return ZW'(s);
  endfunction

  function automatic logic [31:0] atan_rom(input logic [4:0] i);
    logic [31:0] r;
    unique case (i)
      5'd0:    r = 32'h1921FB54;
      5'd1:    r = 32'h0ED63383;
      5'd2:    r = 32'h07D6DD7E;
      5'd3:    r = 32'h03FAB753;
      5'd4:    r = 32'h01FF55BB;
      5'd5:    r = 32'h00FFEAAE;
      5'd6:    r = 32'h007FFD55;
      5'd7:    r = 32'h003FFFAB;
      5'd8:    r = 32'h001FFFF5;
      5'd9:    r = 32'h000FFFFF;
      default: r = 32'h1 << (5'd29 - i);
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] narrow(input logic signed [XW-1:0] v);
`ifdef CORDIC_SAT_EN
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    hi = XW'((2 ** (WIDTH - 1)) - 1);
    lo = -hi - XW'(1);
    if (v > hi) return hi[WIDTH-1:0];
    else if (v < lo) return lo[WIDTH-1:0];
    else return v[WIDTH-1:0];
`else
    return v[WIDTH-1:0];
`endif
  endfunction

  localparam logic signed [ZW-1:0] PI_Z     = scale(32'h6487ED51);
  localparam logic signed [ZW-1:0] HALF_PI  = scale(32'h3243F6A8);
  localparam logic signed [ZW-1:0] TWO_PI   = PI_Z + PI_Z;
  localparam logic [4:0]           LAST_IT  = 5'(ITERATIONS - 1);

  state_e               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [4:0]           iter_q, iter_d;
  logic [WIDTH-1:0]     cos_q, cos_d, sin_q, sin_d;
  logic                 done_q, done_d;
  logic signed [ZW-1:0] zr, at;
  logic signed [XW-1:0] xs, ys;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    done_d  = done_q;
    zr      = z_q;
    at      = scale(atan_rom(iter_q));
    xs      = x_q >>> iter_q;
    ys      = y_q >>> iter_q;
    unique case (state_q)
      IDLE, DONE: begin
        // outputs load one cycle after entering DONE; start waits for that
        if (state_q == DONE && !done_q) begin
          cos_d  = narrow(x_q);
          sin_d  = narrow(y_q);
          done_d = 1'b1;
        end else if (start) begin
          x_d     = XW'($signed(x_start));
          y_d     = XW'($signed(y_start));
          z_d     = ZW'($signed(angle));
          done_d  = 1'b0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (z_q > PI_Z) zr = z_q - TWO_PI;
        else if (z_q < -PI_Z) zr = z_q + TWO_PI;
        z_d = zr;
        if (zr > HALF_PI) begin
          z_d = zr - PI_Z;
          x_d = -x_q;
          y_d = -y_q;
        end else if (zr < -HALF_PI) begin
          z_d = zr + PI_Z;
          x_d = -x_q;
          y_d = -y_q;
        end
        iter_d  = '0;
        state_d = ROTATE;
      end
      ROTATE: begin
        if (!z_q[ZW-1]) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - at;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + at;
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_IT) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      done_q  <= done_d;
    end
  end

  assign cosine = cos_q;
  assign sine   = sin_q;
  assign done   = done_q;

endmodule

// File: tb/tb_cordic.sv
// Directed-vector bench for cordic: sin/cos values, latency and control cases.
module tb_cordic;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] x_start;
  logic [15:0] y_start;
  logic [31:0] angle;
  logic [15:0] cosine;
  logic [15:0] sine;
  logic        done;

  int n_chk = 0;
  int n_ok  = 0;

  cordic dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .x_start(x_start),
    .y_start(y_start),
    .angle  (angle),
    .cosine (cosine),
    .sine   (sine),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp, input int tol);
    int d;
    n_chk++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d <= tol) n_ok++;
    else $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
  endtask

  task automatic run(input string tag, input logic [31:0] a,
                     input int ec, input int es, input int pulse);
    int cnt;
    x_start = 16'h26DD;
    y_start = 16'h0000;
    angle   = a;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cnt   = 0;
    while (!done && cnt < 40) begin
      start = (cnt == pulse);
      @(posedge clock);
      #1;
      cnt++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, cnt, 17, 0);
    chk({tag, "_cos"}, int'($signed(cosine)), ec, 164);
    chk({tag, "_sin"}, int'($signed(sine)), es, 164);
  endtask

  initial begin
    int seen;
    reset   = 1'b1;
    start   = 1'b0;
    x_start = '0;
    y_start = '0;
    angle   = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_done", int'(done), 0, 0);
    chk("rst_cos", int'(cosine), 0, 0);
    chk("rst_sin", int'(sine), 0, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run("zero", 32'h00000000, 16384, 0, -1);
    run("pi2", 32'h3243F6A8, 0, 16384, -1);
    run("pi", 32'h6487ED51, -16384, 0, -1);
    run("mpi2", 32'hCDBC0958, 0, -16384, -1);
    run("four", 32'h7FFFFFFF, -10709, -12399, -1);
    // pi/4: cos = sin = 0.7071 * 16384
    run("pi4", 32'h1921FB54, 11585, 11585, -1);
    run("repulse", 32'h3243F6A8, 0, 16384, 5);

    x_start = 16'h26DD;
    angle   = 32'h6487ED51;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort_done", int'(done), 0, 0);
    chk("abort_cos", int'(cosine), 0, 0);
    chk("abort_sin", int'(sine), 0, 0);
    seen = 0;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (done) seen = 1;
    end
    chk("abort_nodone", seen, 0, 0);

    run("after", 32'hCDBC0958, 0, -16384, -1);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
